// File: rtl/gs_pe_pipe.sv
// Flow-controlled Gauss-Seidel PE: out = floor((b<<B_SHIFT + p0 - 6*p34 + 13*p56) / 20).
// Define GS_PE_SAT_EN to clamp the result to IN_W bits and expose out_sat.
module gs_pe_pipe #(
    parameter int IN_W    = 32,
    parameter int B_W     = 16,
    parameter int B_SHIFT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_1,
    input  logic signed [IN_W-1:0] in_2,
    input  logic signed [IN_W-1:0] in_3,
    input  logic signed [IN_W-1:0] in_4,
    input  logic signed [IN_W-1:0] in_5,
    input  logic signed [IN_W-1:0] in_6,
    input  logic signed [B_W-1:0]  b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out
`ifdef GS_PE_SAT_EN
    ,
    output logic                   out_sat
`endif
);

    localparam int ACC_W = ((IN_W > B_W + B_SHIFT) ? IN_W : (B_W + B_SHIFT)) + 6;
    localparam int DW    = ACC_W - 2;
    localparam int NW    = ACC_W;
    localparam int SH    = NW + 3;
    localparam int PW    = NW + SH;

    // floor(acc/20) = floor(floor(acc/4)/5); the /5 runs on a biased, non-negative
    // operand with a reciprocal that is exact for every operand below 2^NW.
    localparam logic [PW-1:0] RECIP = ((PW'(1) << SH) / PW'(5)) + PW'(1);
    localparam logic [NW-1:0] BIAS  = NW'(5) << (DW - 1);
    localparam logic [NW-1:0] Q_OFF = NW'(1) << (DW - 1);

    logic                    en;
    logic                    v1_q, v2_q, v3_q, out_valid_q;
    logic signed [ACC_W-1:0] s34, s56;
    logic signed [ACC_W-1:0] p0_d, p1_d, p2_d, pb_d;
    logic signed [ACC_W-1:0] p0_q, p1_q, p2_q, pb_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic        [NW-1:0]    yb;
    logic        [PW-1:0]    prod;
    logic signed [NW-1:0]    q_d, q_q;
    logic        [IN_W-1:0]  out_d, out_q;
    logic                    unused_bits;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    always_comb begin
        s34  = ACC_W'(in_3) + ACC_W'(in_4);
        s56  = ACC_W'(in_5) + ACC_W'(in_6);
        p0_d = ACC_W'(in_1) + ACC_W'(in_2);
        p1_d = (s34 <<< 2) + (s34 <<< 1);
        p2_d = (s56 <<< 3) + (s56 <<< 2) + s56;
        pb_d = ACC_W'(b) <<< B_SHIFT;
    end

    assign acc_d = pb_q + p0_q - p1_q + p2_q;

    always_comb begin
        yb   = {{2{acc_q[ACC_W-1]}}, acc_q[ACC_W-1:2]} + BIAS;
        prod = PW'(yb) * RECIP;
        q_d  = prod[PW-1:SH] - Q_OFF;
    end

`ifdef GS_PE_SAT_EN
    localparam logic signed [NW-1:0] OUT_MAX = {{(NW-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [NW-1:0] OUT_MIN = {{(NW-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};
    logic sat_d, sat_q;

    always_comb begin
        out_d = q_q[IN_W-1:0];
        sat_d = 1'b0;
        if (q_q > OUT_MAX) begin
            out_d = OUT_MAX[IN_W-1:0];
            sat_d = 1'b1;
        end else if (q_q < OUT_MIN) begin
            out_d = OUT_MIN[IN_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (en) begin
            sat_q <= sat_d;
        end
    end

    assign out_sat     = sat_q;
    assign unused_bits = ^prod[SH-1:0];
`else
    assign out_d       = q_q[IN_W-1:0];
    assign unused_bits = ^{prod[SH-1:0], q_q[NW-1:IN_W]};
`endif

    // One enable advances every stage together, so bubbles stay in place and order is FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            pb_q        <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            out_q       <= '0;
        end else if (en) begin
            v1_q        <= in_valid && in_ready;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= v3_q;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            pb_q        <= pb_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            out_q       <= out_d;
        end
    end

endmodule
